tcdm_rr_arbiter: RTL

TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

---
 rtl/tcdm_arb_pkg.sv | 20 ++
 rtl/tcdm_rr_arbiter_if.sv | 66 ++++++
 rtl/tcdm_arb_resp_fifo.sv | 77 +++++++
 rtl/tcdm_rr_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tcdm_arb_pkg.sv
// Shared types and defaults for the TCDM round-robin arbiter.
package tcdm_arb_pkg;

  localparam int unsigned NR_DEFAULT        = 2;
  localparam int unsigned MAX_OUTST_DEFAULT = 2;
  localparam int unsigned NR_MAX            = 8;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Sized for the largest supported port count so every NR shares one type.
  localparam int unsigned PORT_IDX_W = $clog2(NR_MAX);
  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    port_idx_t port;
  } fifo_entry_t;

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Requester- and memory-side bus bundle of the TCDM arbiter.
// With TCDM_ARB_PERF_EN defined the per-port perf counter outputs are added.
interface tcdm_rr_arbiter_if
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT
);

  logic [NR-1:0]             in_req_i;
  logic [NR-1:0]             in_gnt_o;
  logic [NR-1:0][ADDR_W-1:0] in_add_i;
  logic [NR-1:0][DATA_W-1:0] in_data_i;
  logic [NR-1:0]             in_wen_i;
  logic [NR-1:0][BE_W-1:0]   in_be_i;
  logic [NR-1:0][DATA_W-1:0] in_r_data_o;
  logic [NR-1:0]             in_r_valid_o;

  logic                      out_req_o;
  logic                      out_wen_o;
  logic [ADDR_W-1:0]         out_add_o;
  logic [DATA_W-1:0]         out_data_o;
  logic [BE_W-1:0]           out_be_o;
  logic                      out_gnt_i;
  logic                      out_r_valid_i;
  logic [DATA_W-1:0]         out_r_data_i;

  logic                      err_o;

`ifdef TCDM_ARB_PERF_EN
  logic [NR-1:0][31:0]       perf_gnt_o;
  logic [NR-1:0][31:0]       perf_stall_o;

  modport slave (
    input  in_req_i, in_add_i, in_data_i, in_wen_i, in_be_i,
    input  out_gnt_i, out_r_valid_i, out_r_data_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_wen_o, out_add_o, out_data_o, out_be_o,
    output err_o, perf_gnt_o, perf_stall_o
  );

  modport master (
    output in_req_i, in_add_i, in_data_i, in_wen_i, in_be_i,
    output out_gnt_i, out_r_valid_i, out_r_data_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_wen_o, out_add_o, out_data_o, out_be_o,
    input  err_o, perf_gnt_o, perf_stall_o
  );
`else
  modport slave (
    input  in_req_i, in_add_i, in_data_i, in_wen_i, in_be_i,
    input  out_gnt_i, out_r_valid_i, out_r_data_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_wen_o, out_add_o, out_data_o, out_be_o,
    output err_o
  );

  modport master (
    output in_req_i, in_add_i, in_data_i, in_wen_i, in_be_i,
    output out_gnt_i, out_r_valid_i, out_r_data_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_wen_o, out_add_o, out_data_o, out_be_o,
    input  err_o
  );
`endif

endinterface

// File: rtl/tcdm_arb_resp_fifo.sv
// In-order FIFO of port indices for transactions still awaiting a response.
module tcdm_arb_resp_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTST_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output fifo_entry_t head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        cnt_q, cnt_d;
  fifo_entry_t mem_q [DEPTH];
  fifo_entry_t mem_d [DEPTH];
  logic        do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    full_o  = (cnt_q == DEPTH_C);
    empty_o = (cnt_q == '0);
    head_o  = mem_q[rd_ptr_q];
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;

    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - cnt_t'(1);
    end

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data only; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin N:1 TCDM arbiter with in-order response routing and a sticky error flag.
// Optional per-port grant/stall counters are enabled with macro TCDM_ARB_PERF_EN.
module tcdm_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NR        = NR_DEFAULT,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEFAULT
) (
  input logic              clk_i,
  input logic              rst_i,
  tcdm_rr_arbiter_if.slave bus
);

  localparam int        NR_I      = int'(NR);
  localparam port_idx_t LAST_PORT = port_idx_t'(NR - 1);

  port_idx_t     rr_ptr_q, rr_ptr_d;
  port_idx_t     win_idx;
  int            win_dist, cand_dist;
  logic          any_req, out_req, handshake, rsp_pop;
  logic          fifo_full, fifo_empty;
  logic          err_q, err_d;
  logic [NR-1:0] gnt_vec, rvalid_vec;
  fifo_entry_t   push_entry, head_entry;

  // Winner is the requester with the smallest cyclic distance from rr_ptr.
  always_comb begin
    win_idx   = '0;
    win_dist  = NR_I;
    cand_dist = 0;
    for (int i = 0; i < NR_I; i++) begin
      cand_dist = i - int'(rr_ptr_q);
      if (cand_dist < 0) begin
        cand_dist = cand_dist + NR_I;
      end
      if (bus.in_req_i[i] && (cand_dist < win_dist)) begin
        win_dist = cand_dist;
        win_idx  = port_idx_t'(i);
      end
    end
  end

  always_comb begin
    any_req   = |bus.in_req_i;
    // A full FIFO blocks new requests even if a response frees a slot this cycle.
    out_req   = any_req & ~fifo_full & ~rst_i;
    handshake = out_req & bus.out_gnt_i;

    bus.out_req_o  = out_req;
    bus.out_add_o  = '0;
    bus.out_data_o = '0;
    bus.out_wen_o  = 1'b0;
    bus.out_be_o   = '0;
    gnt_vec        = '0;
    for (int i = 0; i < NR_I; i++) begin
      if (win_idx == port_idx_t'(i)) begin
        bus.out_add_o  = bus.in_add_i[i];
        bus.out_data_o = bus.in_data_i[i];
        bus.out_wen_o  = bus.in_wen_i[i];
        bus.out_be_o   = bus.in_be_i[i];
        gnt_vec[i]     = handshake;
      end
    end
    bus.in_gnt_o = gnt_vec;

    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (win_idx == LAST_PORT) ? '0 : win_idx + port_idx_t'(1);
    end
    push_entry.port = win_idx;
  end

  always_comb begin
    rsp_pop    = bus.out_r_valid_i & ~fifo_empty & ~rst_i;
    rvalid_vec = '0;
    for (int i = 0; i < NR_I; i++) begin
      rvalid_vec[i] = rsp_pop & (head_entry.port == port_idx_t'(i));
    end
    bus.in_r_valid_o = rvalid_vec;
    bus.in_r_data_o  = {NR{bus.out_r_data_i}};
    // A response with nothing outstanding is dropped and latched as an error.
    err_d            = err_q | (bus.out_r_valid_i & fifo_empty);
    bus.err_o        = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  tcdm_arb_resp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (handshake),
    .push_data_i (push_entry),
    .pop_i       (rsp_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_entry)
  );

`ifdef TCDM_ARB_PERF_EN
  logic [NR-1:0][31:0] perf_gnt_q, perf_gnt_d;
  logic [NR-1:0][31:0] perf_stall_q, perf_stall_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    perf_gnt_d   = perf_gnt_q;
    perf_stall_d = perf_stall_q;
    for (int i = 0; i < NR_I; i++) begin
      if (gnt_vec[i]) begin
        perf_gnt_d[i] = sat_inc(perf_gnt_q[i]);
      end
      if (bus.in_req_i[i] && !gnt_vec[i]) begin
        perf_stall_d[i] = sat_inc(perf_stall_q[i]);
      end
    end
    bus.perf_gnt_o   = perf_gnt_q;
    bus.perf_stall_o = perf_stall_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_gnt_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_gnt_q   <= perf_gnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule
